// File: rtl/sign_code_buffer.sv
// Stability filter + repeat suppression + FIFO for gesture sign codes.
// Optional macro SIGN_DROP_COUNT_EN builds a saturating dropped-commit counter on DROP_CNT.
module sign_code_buffer #(
    parameter int                 WIDTH     = 6,
    parameter int                 DEPTH     = 8,
    parameter int                 STABLE    = 3,
    parameter logic [WIDTH-1:0]   IDLE_CODE = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           CODE_IN,
    input  logic                       CODE_VLD,
    output logic [WIDTH-1:0]           CODE_OUT,
    output logic                       OUT_VLD,
    input  logic                       OUT_RDY,
    output logic                       FULL,
    output logic [$clog2(DEPTH):0]     COUNT,
    output logic                       OVF,
    output logic [7:0]                 DROP_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(STABLE + 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   cand, cand_nxt;
    logic [RW-1:0]      run, run_nxt;
    logic [WIDTH-1:0]   last, last_nxt;
    logic               commit, push, pop, accept, drop;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [AW:0]        count;

    // Filter: a code commits on the edge its run length reaches STABLE.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        run_nxt   = run;
        commit    = 1'b0;
        if (CODE_VLD) begin
            case (state)
                IDLE: begin
                    cand_nxt  = CODE_IN;
                    run_nxt   = RW'(1);
                    state_nxt = TRACK;
                end
                TRACK: begin
                    if (CODE_IN == cand) begin
                        run_nxt = run + RW'(1);
                        if (run + RW'(1) == RW'(STABLE)) begin
                            state_nxt = LOCKED;
                            commit    = 1'b1;
                        end
                    end else begin
                        cand_nxt = CODE_IN;
                        run_nxt  = RW'(1);
                    end
                end
                LOCKED: begin
                    if (CODE_IN != cand) begin
                        cand_nxt  = CODE_IN;
                        run_nxt   = RW'(1);
                        state_nxt = TRACK;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Repeat suppression: the same letter is only re-queued after an idle commit.
    always_comb begin
        last_nxt = last;
        push     = 1'b0;
        if (commit) begin
            if (cand == IDLE_CODE) begin
                last_nxt = IDLE_CODE;
            end else if (cand != last) begin
                last_nxt = cand;
                push     = 1'b1;
            end
        end
    end

    assign pop    = OUT_VLD & OUT_RDY;
    assign accept = push & (~FULL | pop);
    assign drop   = push & ~accept;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cand  <= IDLE_CODE;
            run   <= '0;
            last  <= IDLE_CODE;
        end else begin
            state <= state_nxt;
            cand  <= cand_nxt;
            run   <= run_nxt;
            last  <= last_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) mem[wr_ptr] <= cand;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            OVF    <= 1'b0;
        end else begin
            OVF <= drop;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is masked while empty so the output reads zero out of reset.
    assign OUT_VLD  = (count != '0);
    assign FULL     = (count == (AW+1)'(DEPTH));
    assign COUNT    = count;
    assign CODE_OUT = OUT_VLD ? mem[rd_ptr] : '0;

`ifdef SIGN_DROP_COUNT_EN
    logic [7:0] drop_cnt;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                          drop_cnt <= 8'd0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
    assign DROP_CNT = drop_cnt;
`else
    assign DROP_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_sign_code_buffer.sv
// Randomized + directed bench for sign_code_buffer against a queue-based reference model.
module tb_sign_code_buffer;
    localparam int WIDTH = 6, DEPTH = 8, STABLE = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [WIDTH-1:0] CODE_IN = '0;
    logic             CODE_VLD = 1'b0;
    logic [WIDTH-1:0] CODE_OUT;
    logic             OUT_VLD;
    logic             OUT_RDY = 1'b0;
    logic             FULL;
    logic [3:0]       COUNT;
    logic             OVF;
    logic [7:0]       DROP_CNT;

    sign_code_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE(STABLE), .IDLE_CODE(6'd0)) dut (
        .CLK(CLK), .RST(RST), .CODE_IN(CODE_IN), .CODE_VLD(CODE_VLD),
        .CODE_OUT(CODE_OUT), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY),
        .FULL(FULL), .COUNT(COUNT), .OVF(OVF), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // Reference model: run length of the current candidate (0 = nothing seen yet).
    int m_cand, m_len, m_last, m_drops;
    bit m_ovf;
    int q[$];

    function automatic void m_clear();
        m_cand = 0; m_len = 0; m_last = 0; m_drops = 0; m_ovf = 0;
        q.delete();
    endfunction

    function automatic void m_edge(bit vld, int s, bit rdy);
        bit commit = 0, push = 0, pop;
        int pre = q.size();
        pop = (pre > 0) && rdy;
        if (vld) begin
            if (m_len > 0 && s == m_cand) begin
                if (m_len < STABLE) begin
                    m_len++;
                    commit = (m_len == STABLE);
                end
            end else begin
                m_cand = s;
                m_len  = 1;
            end
        end
        if (commit) begin
            if (m_cand == 0) m_last = 0;
            else if (m_cand != m_last) begin m_last = m_cand; push = 1; end
        end
        if (pop) void'(q.pop_front());
        m_ovf = 0;
        if (push) begin
            if (pre < DEPTH || pop) q.push_back(m_cand);
            else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
    endfunction

    task automatic cmp_all(input string tag);
        chk({tag, ".vld"},   int'(OUT_VLD),  int'(q.size() > 0));
        chk({tag, ".code"},  int'(CODE_OUT), (q.size() > 0) ? q[0] : 0);
        chk({tag, ".count"}, int'(COUNT),    q.size());
        chk({tag, ".full"},  int'(FULL),     int'(q.size() == DEPTH));
        chk({tag, ".ovf"},   int'(OVF),      int'(m_ovf));
`ifdef SIGN_DROP_COUNT_EN
        chk({tag, ".drops"}, int'(DROP_CNT), m_drops);
`else
        chk({tag, ".drops"}, int'(DROP_CNT), 0);
`endif
    endtask

    task automatic step(input bit vld, input int s, input bit rdy, input string tag);
        @(negedge CLK);
        CODE_VLD = vld; CODE_IN = WIDTH'(s); OUT_RDY = rdy;
        @(posedge CLK);
        m_edge(vld, s, rdy);
        #1 cmp_all(tag);
    endtask

    task automatic feed(input int s, input int n, input bit rdy, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, s, rdy, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b0;
        m_clear();
        for (int i = 0; i < 3; i++) begin
            CODE_VLD = 1'($urandom); CODE_IN = WIDTH'($urandom); OUT_RDY = 1'($urandom);
            @(posedge CLK);
            #1 cmp_all(tag);
            @(negedge CLK);
        end
        CODE_VLD = 1'b0; OUT_RDY = 1'b0;
        RST = 1'b1;
    endtask

    initial begin
        m_clear();
        do_reset("rst");

        // first commit latency
        feed(5, 2, 0, "lat");
        chk("lat.early", int'(OUT_VLD), 0);
        feed(5, 1, 0, "lat");
        chk("lat.code", int'(CODE_OUT), 5);

        do_reset("rst2");
        feed(5, 2, 0, "glitch");
        feed(7, 3, 0, "glitch");
        chk("glitch.count", int'(COUNT), 1);
        chk("glitch.head", int'(CODE_OUT), 7);

        do_reset("rst3");
        feed(5, 6, 0, "rep"); feed(0, 3, 0, "rep"); feed(5, 3, 0, "rep");
        chk("rep.gap.count", int'(COUNT), 2);
        do_reset("rst4");
        feed(5, 6, 0, "rep2"); feed(5, 3, 0, "rep2");
        chk("rep.nogap.count", int'(COUNT), 1);

        do_reset("rst5");
        for (int c = 1; c <= 4; c++) feed(c, 3, 0, "stall");
        step(1'b0, 0, 1'b0, "stall.hold");
        chk("stall.head", int'(CODE_OUT), 1);
        for (int c = 1; c <= 4; c++) begin
            chk("stall.seq", int'(CODE_OUT), c);
            step(1'b0, 0, 1'b1, "drain");
        end
        chk("stall.empty", int'(OUT_VLD), 0);

        do_reset("rst6");
        for (int c = 1; c <= 9; c++) begin
            feed(c, 2, 0, "ovf");
            @(negedge CLK);
            CODE_VLD = 1'b1; CODE_IN = WIDTH'(c); OUT_RDY = 1'b0;
            @(posedge CLK);
            m_edge(1'b1, c, 1'b0);
            #1 cmp_all("ovf");
            if (c == 9) chk("ovf.pulse", int'(OVF), 1);
        end
        step(1'b0, 0, 1'b0, "ovf.after");
        chk("ovf.one_cycle", int'(OVF), 0);
        chk("ovf.count", int'(COUNT), 8);
        chk("ovf.full", int'(FULL), 1);
        feed(10, 2, 0, "ovf.pop");
        step(1'b1, 10, 1'b1, "ovf.pop");
        chk("ovf.pop.count", int'(COUNT), 8);
        chk("ovf.pop.noovf", int'(OVF), 0);

        // asynchronous reset with entries queued
        do_reset("rst7");
        for (int c = 1; c <= 3; c++) feed(c, 3, 0, "async");
        chk("async.pre", int'(COUNT), 3);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("async.count", int'(COUNT), 0);
        chk("async.vld", int'(OUT_VLD), 0);
        m_clear();
        @(negedge CLK);
        RST = 1'b1;

        // random soak over a small alphabet so runs actually stabilise
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(9, 0) < 8), int'($urandom_range(3, 0)),
                 ($urandom_range(9, 0) < 3), "rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
